// File: rtl/vga_sync_monitor.sv
// Passive VGA timing receiver: recovers pixel coordinates from HS/VS and
// checks line/frame timing, reporting lock, violations and frame count.
//
// state  | meaning
// HUNT   | no timing reference, waiting for a VS fall
// CHECK  | one reference VS fall seen, verifying the following frame
// LOCKED | timing verified, coordinates valid
module vga_sync_monitor #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_ACT   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_ACT   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       active,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic [7:0] frame_count,
  output logic [9:0] line_len
);

  localparam logic [9:0]  H_TOT_M1  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_SYNC_M1 = 10'(H_SYNC - 1);
  localparam logic [9:0]  X_START   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  X_END     = 10'(H_SYNC + H_BACK + H_ACT);
  localparam logic [9:0]  Y_START   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  Y_END     = 10'(V_SYNC + V_BACK + V_ACT);
  localparam logic [9:0]  V_TOT_M1  = 10'(V_TOTAL - 1);
  localparam logic [10:0] V_TOT11   = 11'(V_TOTAL);
  localparam logic [3:0]  V_SYNC4   = 4'(V_SYNC);

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [3:0]  vs_w_q, vs_w_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic [9:0]  line_len_q, line_len_d;
  logic        err_pulse_q, err_pulse_d;
  logic [7:0]  err_count_q, err_count_d, frame_count_q, frame_count_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        active_q, active_d, locked_q, locked_d;

  logic        hs_fall, hs_rise, vs_fall, vs_rise, viol, in_win;
  logic [10:0] frame_len;

  assign hs_fall   = hs_q & ~hs_in;
  assign hs_rise   = ~hs_q & hs_in;
  assign vs_fall   = vs_q & ~vs_in;
  assign vs_rise   = ~vs_q & vs_in;
  assign frame_len = {1'b0, v_cnt_q} + {10'd0, hs_fall};

  always_comb begin
    state_d       = state_q;
    hs_d          = hs_in;
    vs_d          = vs_in;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    vs_w_d        = vs_w_q;
    h_seen_d      = h_seen_q;
    v_seen_d      = v_seen_q;
    line_len_d    = line_len_q;
    err_count_d   = err_count_q;
    frame_count_d = frame_count_q;
    x_d           = 10'd0;
    y_d           = 10'd0;
    active_d      = 1'b0;
    viol          = 1'b0;

    // Overlong lines are flagged once at H_TOTAL; the late fall is not re-flagged.
    if (hs_fall) begin
      h_cnt_d  = 10'd0;
      h_seen_d = 1'b1;
      if (h_seen_q) begin
        line_len_d = (h_cnt_q == 10'h3FF) ? 10'h3FF : h_cnt_q + 10'd1;
        if (h_cnt_q < H_TOT_M1) viol = 1'b1;
      end
    end else begin
      if (h_cnt_q != 10'h3FF) h_cnt_d = h_cnt_q + 10'd1;
      if (h_seen_q && h_cnt_q == H_TOT_M1) viol = 1'b1;
    end
    if (hs_rise && h_seen_q && h_cnt_q != H_SYNC_M1) viol = 1'b1;

    if (vs_fall) begin
      v_cnt_d  = 10'd0;
      v_seen_d = 1'b1;
      vs_w_d   = hs_fall ? 4'd1 : 4'd0;
      if (v_seen_q && frame_len < V_TOT11) viol = 1'b1;
    end else begin
      if (hs_fall) begin
        if (v_cnt_q != 10'h3FF) v_cnt_d = v_cnt_q + 10'd1;
        if (v_seen_q && v_cnt_q == V_TOT_M1) viol = 1'b1;
        if (!vs_in && vs_w_q != 4'hF) vs_w_d = vs_w_q + 4'd1;
      end
    end
    if (vs_rise && v_seen_q && vs_w_q != V_SYNC4) viol = 1'b1;

    case (state_q)
      HUNT:    if (vs_fall) state_d = CHECK;
      CHECK:   if (viol) state_d = HUNT; else if (vs_fall) state_d = LOCKED;
      LOCKED:  if (viol) state_d = HUNT;
      default: state_d = HUNT;
    endcase

    err_pulse_d = viol;
    if (viol && state_q != HUNT && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    if (vs_fall && state_q == LOCKED) frame_count_d = frame_count_q + 8'd1;
    locked_d = (state_d == LOCKED);

    in_win = (h_cnt_q >= X_START) && (h_cnt_q < X_END) &&
             (v_cnt_q >= Y_START) && (v_cnt_q < Y_END);
    if (in_win && state_q == LOCKED) begin
      active_d = 1'b1;
      x_d      = h_cnt_q - X_START;
      y_d      = v_cnt_q - Y_START;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      vs_w_q        <= 4'd0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      line_len_q    <= 10'd0;
      err_pulse_q   <= 1'b0;
      err_count_q   <= 8'd0;
      frame_count_q <= 8'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      active_q      <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vs_w_q        <= vs_w_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      line_len_q    <= line_len_d;
      err_pulse_q   <= err_pulse_d;
      err_count_q   <= err_count_d;
      frame_count_q <= frame_count_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      locked_q      <= locked_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign active      = active_q;
  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;
  assign frame_count = frame_count_q;
  assign line_len    = line_len_q;

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Self-check receiver for the VGA timing interface. It samples the horizontal and vertical sync lines driven toward the monitor and recovers the pixel coordinate stream from them. It also checks every line and frame against 640x480@60 timing and reports lock and error status. It sits on the pixel clock beside the VGA controller and can also be connected to external sync pins for board bring-up.

## Interface
- H_SYNC, 96: HS pulse width, in pixel clocks.
- H_BACK, 48: horizontal back porch, in pixel clocks.
- H_ACT, 640: active pixels per line.
- H_TOTAL, 800: pixel clocks per line.
- V_SYNC, 2: VS pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- V_ACT, 480: active lines per frame.
- V_TOTAL, 525: lines per frame.
- clk  in  1  pixel clock (25 MHz vga_clk); one sample per pixel.
- reset  in  1  asynchronous, active-high; clears all state.
- hs_in  in  1  HS under test, active-low.
- vs_in  in  1  VS under test, active-low.
- x_out  out  10  recovered column; 0 outside the active window.
- y_out  out  10  recovered row; 0 outside the active window.
- active  out  1  high when locked and inside the active window.
- locked  out  1  timing verified.
- err_pulse  out  1  one-cycle pulse per detected violation.
- err_count  out  8  violations counted while not in HUNT; saturates at 255.
- frame_count  out  8  VS falls counted while LOCKED; wraps at 255 to 0.
- line_len  out  10  length of the last completed line, in clocks.

## Operation
**Edge detection**
- hs_q and vs_q register the inputs and reset to 1.
- HS fall = hs_q & ~hs_in; HS rise = ~hs_q & hs_in. VS edges use the same form.

**Horizontal counter (h_cnt, 10 bits)**
- Loads 0 on the edge that detects an HS fall.
- Otherwise increments, saturating at 1023.
- On each HS fall, line_len ← h_cnt+1. This update is skipped for the first fall after reset.

**Vertical counter (v_cnt, 10 bits)**
- Increments on each HS fall, saturating at 1023.
- Loads 0 on a VS fall. This takes precedence when VS and HS fall on the same edge.

**Measurement definitions**
- HS width: consecutive samples with hs_in = 0.
- Line period: samples from one HS fall to the next.
- VS width: HS falls seen while vs_in is low, including one that coincides with the VS fall.
- Frame period: HS falls from one VS fall to the next.

**Violations** (each raises err_pulse exactly once)
- Line period ≠ H_TOTAL.
  - An overlong line is flagged when h_cnt reaches H_TOTAL with no fall.
  - The late fall that ends an overlong line is not flagged again.
- HS width ≠ H_SYNC, checked at the HS rise.
- VS width ≠ V_SYNC, checked at the VS rise.
- Frame period ≠ V_TOTAL.
  - An overlong frame is flagged when v_cnt reaches V_TOTAL.
- No violation is checked until the first HS fall after reset (for line checks) or the first VS fall (for frame checks).

**Lock FSM**
- HUNT: on a VS fall → CHECK.
- CHECK:
  - Any violation → HUNT.
  - Next VS fall with no violation during the frame → LOCKED.
- LOCKED:
  - Any violation → HUNT.
  - Each VS fall increments frame_count.
- locked = (state == LOCKED).

**Coordinates**
- Window: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACT) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACT).
- x_out = h_cnt − (H_SYNC+H_BACK); y_out = v_cnt − (V_SYNC+V_BACK).
- Subtraction is 10-bit and is valid only inside the window. Outside the window, or when not locked, x_out = y_out = 0 and active = 0.

## Timing
- Reset values:
  - All outputs 0.
  - State HUNT.
  - hs_q = vs_q = 1.
  - Counters 0; "first fall seen" flags cleared.
- If hs_in or vs_in is low at reset release, the first clock edge sees a fall. This is defined behaviour.
- Reset asserted mid-operation clears everything asynchronously, including a pending err_pulse.
- All outputs are registered.
- x_out, y_out and active are valid on the clock edge after h_cnt and v_cnt.
  - Total latency from the sampled HS fall to x/y reflecting that line: 2 clocks.
- err_pulse asserts on the clock edge after the violating sample. State leaves LOCKED or CHECK on the same edge, so locked falls together with err_pulse.
- err_count increments with err_pulse when state ≠ HUNT. A violation that moves the state to HUNT is still counted.
- locked rises on the edge after the second clean VS fall, which is two VS falls after leaving HUNT.

## Test plan
- Nominal stream, 3 frames:
  - locked rises one clock after the 2nd VS fall.
  - err_count stays 0.
  - active first rises with x_out = 0, y_out = 0 at h_cnt = 144, v_cnt = 35.
  - The last active pixel is x_out = 639, y_out = 479.
  - line_len = 800.
- While locked, stretch one line to 801 clocks:
  - err_pulse fires at h_cnt = 800 and locked drops the same cycle.
  - err_count = 1; line_len = 801 after the late fall.
  - Relock occurs after 2 further clean VS falls.
- HS held high after lock: exactly one err_pulse, at 800 clocks after the last fall; h_cnt saturates at 1023 with no further pulses.
- VS width of 3 lines while in CHECK: err_pulse at the VS rise, state returns to HUNT, err_count = 1.
- Reset asserted mid-frame while locked: all outputs are 0 immediately; after release the block relocks from HUNT in 2 frames.
- 256 clean frames after lock: frame_count wraps from 255 to 0 and err_count stays 0.
